// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: frames one byte as start, data (LSB first), optional parity, stop bits.
// Every output is registered. A frame starts on the line one cycle after its handshake.
module uart_tx_sequencer #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       SysClk,
  input  logic       Rst,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic       TxD,
  output logic       Busy,
  output logic       BitTick,
  output logic       Done
);

  localparam int BIT_DIV = SYSCLK_RATE / BAUD_RATE;
  localparam int CNT_W   = (BIT_DIV >= 2) ? $clog2(BIT_DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);

  if (BIT_DIV < 2) begin : g_bad_div
    $error("uart_tx_sequencer: SYSCLK_RATE/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_sequencer: DATA_BITS must be within 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_sequencer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       data_reg;
  logic             parity_reg;
  logic             pend;
  logic             handshake;
  logic             bit_end;

  logic             txd_nxt;
  logic             ready_nxt;
  logic             busy_nxt;
  logic             tick_nxt;
  logic             done_nxt;

  // TxReady is only ever high in IDLE, so a handshake implies IDLE.
  assign handshake = TxValid && TxReady;
  assign bit_end   = (div_cnt == DIV_LAST);

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_idx    <= '0;
      pend       <= 1'b0;
      data_reg   <= '0;
      parity_reg <= 1'b0;
      TxD        <= 1'b1;
      TxReady    <= 1'b1;
      Busy       <= 1'b0;
      BitTick    <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      pend    <= handshake;
      if (handshake) begin
        data_reg   <= TxData & DATA_MASK;
        parity_reg <= (^(TxData & DATA_MASK)) ^ (PARITY_ODD != 0);
      end
      TxD     <= txd_nxt;
      TxReady <= ready_nxt;
      Busy    <= busy_nxt;
      BitTick <= tick_nxt;
      Done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pend) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == DATA_LAST)
                 state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && bit_idx == STOP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Bit index counts data or stop bits and clears whenever the state changes.
    div_cnt_nxt = (state == IDLE || bit_end) ? '0 : div_cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    if (state_nxt != state) begin
      bit_idx_nxt = '0;
    end else if (bit_end) begin
      bit_idx_nxt = bit_idx + 1'b1;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    txd_nxt = 1'b1;
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = data_reg[bit_idx_nxt];
      PARITY:  txd_nxt = parity_reg;
      default: txd_nxt = 1'b1;
    endcase
    busy_nxt  = (state_nxt != IDLE);
    ready_nxt = (state_nxt == IDLE) && !handshake;
    tick_nxt  = (state_nxt != IDLE) && (div_cnt_nxt == '0);
    done_nxt  = (state == STOP) && (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: four configurations (8N1, 8E1, 8O1, 5N2) at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_tx_sequencer;

  localparam int BD = 10;

  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [3:0] tx_valid;
  logic [7:0] tx_data [4];
  wire  [3:0] tx_ready;
  wire  [3:0] txd;
  wire  [3:0] busy;
  wire  [3:0] bit_tick;
  wire  [3:0] done;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_sequencer #(
      .SYSCLK_RATE(100),
      .BAUD_RATE  (10),
      .DATA_BITS  ((g == 3) ? 5 : 8),
      .PARITY_EN  ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD ((g == 2) ? 1 : 0),
      .STOP_BITS  ((g == 3) ? 2 : 1)
    ) u_dut (
      .SysClk (clk),
      .Rst    (rst[g]),
      .TxData (tx_data[g]),
      .TxValid(tx_valid[g]),
      .TxReady(tx_ready[g]),
      .TxD    (txd[g]),
      .Busy   (busy[g]),
      .BitTick(bit_tick[g]),
      .Done   (done[g])
    );
  end

  function automatic int cfg_db(input int g); return (g == 3) ? 5 : 8; endfunction
  function automatic int cfg_pe(input int g); return (g == 1 || g == 2) ? 1 : 0; endfunction
  function automatic int cfg_po(input int g); return (g == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(input int g); return (g == 3) ? 2 : 1; endfunction

  function automatic int frame_bits(input int g);
    return 1 + cfg_db(g) + cfg_pe(g) + cfg_sb(g);
  endfunction

  // Expected line level for bit position k of a frame carrying d.
  function automatic logic line_bit(input int g, input logic [7:0] d, input int k);
    logic [7:0] m;
    m = 8'hFF >> (8 - cfg_db(g));
    if (k == 0) return 1'b0;
    if (k <= cfg_db(g)) return d[k-1];
    if (cfg_pe(g) == 1 && k == cfg_db(g) + 1) return (^(d & m)) ^ (cfg_po(g) == 1);
    return 1'b1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers d, then checks the line cycle by cycle through the Done cycle.
  task automatic send(input int g, input logic [7:0] d, input bit hold_valid,
                      input logic [7:0] nxt_d, input int abort_n, output int waited);
    int len;
    len = frame_bits(g) * BD + 1;
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    waited = 0;
    while (!tx_ready[g] && waited < 20) begin
      step();
      waited++;
    end
    if (!tx_ready[g]) begin
      check_val("hs_timeout", 32'd0, 32'd1);
      tx_valid[g] = 1'b0;
      return;
    end
    step();
    tx_valid[g] = hold_valid;
    tx_data[g]  = nxt_d;
    check_val("post_hs_txd", txd[g], 1'b1);
    check_val("post_hs_done", done[g], 1'b0);
    for (int n = 1; n <= len; n++) begin
      step();
      if (n < len) begin
        check_val($sformatf("g%0d_txd_n%0d", g, n), txd[g], line_bit(g, d, (n - 1) / BD));
        check_val($sformatf("g%0d_tick_n%0d", g, n), bit_tick[g], ((n - 1) % BD) == 0);
        check_val("busy_in_frame", busy[g], 1'b1);
        check_val("done_in_frame", done[g], 1'b0);
        tick_cnt += int'(bit_tick[g]);
        if (n == abort_n) begin
          rst[g] = 1'b1;
          step();
          rst[g] = 1'b0;
          check_val("abort_txd", txd[g], 1'b1);
          check_val("abort_busy", busy[g], 1'b0);
          check_val("abort_ready", tx_ready[g], 1'b1);
          check_val("abort_done", done[g], 1'b0);
          check_val("abort_tick", bit_tick[g], 1'b0);
          for (int k = 0; k < len; k++) begin
            step();
            check_val("abort_no_done", done[g], 1'b0);
          end
          return;
        end
      end else begin
        check_val($sformatf("g%0d_done_at_len", g), done[g], 1'b1);
        check_val("done_ready", tx_ready[g], 1'b1);
        check_val("done_busy", busy[g], 1'b0);
        check_val("done_txd", txd[g], 1'b1);
        check_val("done_tick", bit_tick[g], 1'b0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int g;
    rst      = 4'hF;
    tx_valid = 4'h0;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("rst_txd%0d", i), txd[i], 1'b1);
      check_val($sformatf("rst_ready%0d", i), tx_ready[i], 1'b1);
      check_val($sformatf("rst_busy%0d", i), busy[i], 1'b0);
      check_val($sformatf("rst_tick%0d", i), bit_tick[i], 1'b0);
      check_val($sformatf("rst_done%0d", i), done[i], 1'b0);
    end
    rst = 4'h0;
    step();

    // Directed frames from the specification examples.
    send(0, 8'hA5, 1'b0, 8'($urandom), 0, w);
    send(1, 8'h07, 1'b0, 8'($urandom), 0, w);
    send(2, 8'h07, 1'b0, 8'($urandom), 0, w);
    send(3, 8'hFF, 1'b0, 8'($urandom), 0, w);
    send(3, 8'hE0, 1'b0, 8'($urandom), 0, w);
    repeat (3) step();

    // Back-to-back with TxValid held high.
    tick_cnt = 0;
    send(0, 8'h55, 1'b1, 8'h0F, 0, w);
    send(0, 8'h0F, 1'b0, 8'($urandom), 0, w);
    check_val("b2b_wait", w, 0);
    check_val("b2b_ticks", tick_cnt, 20);
    repeat (2) step();

    // Reset in the middle of data bit 3, then a clean frame.
    send(0, 8'($urandom), 1'b0, 8'($urandom), 45, w);
    send(0, 8'h3C, 1'b0, 8'($urandom), 0, w);

    // Reset coinciding with a handshake drops the frame.
    tx_data[1]  = 8'($urandom);
    tx_valid[1] = 1'b1;
    rst[1]      = 1'b1;
    step();
    rst[1]      = 1'b0;
    tx_valid[1] = 1'b0;
    check_val("rst_hs_ready", tx_ready[1], 1'b1);
    for (int k = 0; k < 40; k++) begin
      step();
      check_val("rst_hs_busy", busy[1], 1'b0);
      check_val("rst_hs_txd", txd[1], 1'b1);
    end

    // Randomized frames across all configurations.
    for (int i = 0; i < 12; i++) begin
      g = int'($urandom_range(0, 3));
      send(g, 8'($urandom), 1'b0, 8'($urandom), 0, w);
      repeat ($urandom_range(0, 3)) step();
    end

    // Idle line stays quiet with TxValid low.
    for (int k = 0; k < 50; k++) begin
      step();
      check_val("idle_txd", txd, 4'hF);
      check_val("idle_busy", busy, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
